// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: sequences a single-register write or read toward a 7-bit slave.
// Each bit slot is four quarters of CLK_DIV cycles. SCL and SDA are registered open-drain
// enables, where 1 releases the line.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rdNotWr,
    input  logic [6:0] devAddr,
    input  logic [7:0] regAddr,
    input  logic [7:0] wrData,
    output logic       busy,
    output logic       done,
    output logic       ackErr,
    output logic [7:0] rdData,
    output logic       sclOut,
    output logic       sdaOut,
    input  logic       sdaIn
);

    typedef enum logic [3:0] {
        StIdle, StStart, StTxByte, StTxAck, StRstart, StRxByte, StRxNack, StStop, StFin
    } stateT;

    localparam logic [9:0] QLast = 10'(CLK_DIV - 1);

    stateT      state;
    logic [9:0] qCnt;
    logic [1:0] quarter;
    logic [2:0] bitCnt;
    logic [1:0] byteIdx;   // 0: address byte, 1: register byte, 2: write-data byte
    logic       afterRs;   // the address byte after a repeated START has been sent
    logic       rdL;
    logic [6:0] devL;
    logic [7:0] regL;
    logic [7:0] wrL;
    logic [7:0] txShift;
    logic [7:0] rxShift;
    logic       qEnd;

    assign qEnd = (qCnt == QLast);

    // Transaction FSM; each quarter boundary sets the bus levels for the next quarter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            qCnt    <= '0;
            quarter <= '0;
            bitCnt  <= '0;
            byteIdx <= '0;
            afterRs <= 1'b0;
            rdL     <= 1'b0;
            devL    <= '0;
            regL    <= '0;
            wrL     <= '0;
            txShift <= '0;
            rxShift <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ackErr  <= 1'b0;
            rdData  <= 8'h00;
            sclOut  <= 1'b1;
            sdaOut  <= 1'b1;
        end else begin
            done <= 1'b0;
            if (state == StIdle) begin
                if (req) begin
                    rdL     <= rdNotWr;
                    devL    <= devAddr;
                    regL    <= regAddr;
                    wrL     <= wrData;
                    ackErr  <= 1'b0;
                    busy    <= 1'b1;
                    state   <= StStart;
                    qCnt    <= '0;
                    quarter <= '0;
                    byteIdx <= '0;
                    afterRs <= 1'b0;
                    sclOut  <= 1'b1;
                    sdaOut  <= 1'b1;
                end
            end else if (state == StFin) begin
                busy  <= 1'b0;
                state <= StIdle;
            end else begin
                qCnt <= qEnd ? '0 : qCnt + 10'd1;
                if (qEnd) begin
                    quarter <= quarter + 2'd1;
                    case (quarter)
                        2'd0: begin
                            case (state)
                                StRstart, StStop: sclOut <= 1'b1;
                                StTxByte: begin
                                    sdaOut  <= txShift[7];
                                    txShift <= {txShift[6:0], 1'b0};
                                end
                                StTxAck, StRxByte, StRxNack: sdaOut <= 1'b1;
                                default: ;
                            endcase
                        end
                        2'd1: begin
                            case (state)
                                StStart, StRstart: sdaOut <= 1'b0;
                                StStop: sdaOut <= 1'b1;
                                StTxByte, StTxAck, StRxByte, StRxNack: sclOut <= 1'b1;
                                default: ;
                            endcase
                        end
                        2'd2: begin
                            case (state)
                                StStart, StRstart: sclOut <= 1'b0;
                                StTxAck: if (sdaIn) ackErr <= 1'b1;
                                StRxByte: rxShift <= {rxShift[6:0], sdaIn};
                                default: ;
                            endcase
                        end
                        default: begin
                            // End of slot: SCL goes low for the next slot's q0.
                            sclOut <= 1'b0;
                            case (state)
                                StStart: begin
                                    state   <= StTxByte;
                                    txShift <= {devL, 1'b0};
                                    bitCnt  <= '0;
                                end
                                StRstart: begin
                                    state   <= StTxByte;
                                    txShift <= {devL, 1'b1};
                                    afterRs <= 1'b1;
                                    bitCnt  <= '0;
                                end
                                StTxByte: begin
                                    bitCnt <= bitCnt + 3'd1;
                                    if (bitCnt == 3'd7) state <= StTxAck;
                                end
                                StRxByte: begin
                                    bitCnt <= bitCnt + 3'd1;
                                    if (bitCnt == 3'd7) state <= StRxNack;
                                end
                                StTxAck: begin
                                    if (ackErr) begin
                                        state  <= StStop;
                                        sdaOut <= 1'b0;
                                    end else if (afterRs) begin
                                        state <= StRxByte;
                                    end else if (byteIdx == 2'd0) begin
                                        state   <= StTxByte;
                                        txShift <= regL;
                                        byteIdx <= 2'd1;
                                    end else if (byteIdx == 2'd1 && rdL) begin
                                        state  <= StRstart;
                                        sdaOut <= 1'b1;
                                    end else if (byteIdx == 2'd1) begin
                                        state   <= StTxByte;
                                        txShift <= wrL;
                                        byteIdx <= 2'd2;
                                    end else begin
                                        state  <= StStop;
                                        sdaOut <= 1'b0;
                                    end
                                end
                                StRxNack: begin
                                    if (!ackErr) rdData <= rxShift;
                                    state  <= StStop;
                                    sdaOut <= 1'b0;
                                end
                                StStop: begin
                                    // Bus stays released after the STOP.
                                    sclOut <= 1'b1;
                                    state  <= StFin;
                                    done   <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a behavioural register slave on the bus, and an expected-result
// model built from the transaction rules. Transactions are directed and random.
module tb_i2c_master_ctrl;

    localparam int unsigned ClkDiv = 16;
    localparam logic [6:0] SlvAddr = 7'h2A;

    logic       clk;
    logic       rst;
    logic       req;
    logic       rdNotWr;
    logic [6:0] devAddr;
    logic [7:0] regAddr;
    logic [7:0] wrData;
    logic       busy;
    logic       done;
    logic       ackErr;
    logic [7:0] rdData;
    logic       sclOut;
    logic       sdaOut;
    logic       slvSda;
    logic       sdaBus;

    assign sdaBus = sdaOut & slvSda;

    i2c_master_ctrl #(.CLK_DIV(ClkDiv)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rdNotWr (rdNotWr),
        .devAddr (devAddr),
        .regAddr (regAddr),
        .wrData  (wrData),
        .busy    (busy),
        .done    (done),
        .ackErr  (ackErr),
        .rdData  (rdData),
        .sclOut  (sclOut),
        .sdaOut  (sdaOut),
        .sdaIn   (sdaBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave register file and bus event counters.
    logic [7:0] slvMem [256];
    int startCnt = 0, rstartCnt = 0, stopCnt = 0, riseCnt = 0, doneCnt = 0;

    // Behavioural slave: samples the bus every falling clock edge.
    initial begin
        logic prevScl, prevSda, scl, sda;
        logic inXfer, active, rxMode, ackPend, txPend;
        logic [7:0] shift, txByte, regPtr;
        int bitPos, byteNum;
        for (int i = 0; i < 256; i++) slvMem[i] = 8'h00;
        slvMem[5] = 8'h3C;
        slvSda = 1'b1;
        prevScl = 1'b1; prevSda = 1'b1; inXfer = 1'b0; active = 1'b0; rxMode = 1'b1;
        ackPend = 1'b0; txPend = 1'b0; shift = '0; txByte = '0; regPtr = '0;
        bitPos = 0; byteNum = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                inXfer = 1'b0; active = 1'b0; slvSda = 1'b1; prevScl = 1'b1; prevSda = 1'b1;
            end else begin
                scl = sclOut;
                sda = sdaBus;
                if (done) doneCnt++;
                if (prevScl && scl && prevSda && !sda) begin
                    if (inXfer) rstartCnt++; else startCnt++;
                    inXfer = 1'b1; active = 1'b1; rxMode = 1'b1; bitPos = 0; byteNum = 0;
                    ackPend = 1'b0; txPend = 1'b0; slvSda = 1'b1;
                end else if (prevScl && scl && !prevSda && sda) begin
                    stopCnt++;
                    inXfer = 1'b0; active = 1'b0; slvSda = 1'b1;
                end else if (!prevScl && scl) begin
                    riseCnt++;
                    if (active) begin
                        if (bitPos < 8) begin
                            if (rxMode) shift = {shift[6:0], sda};
                            bitPos++;
                            if (bitPos == 8 && rxMode) begin
                                ackPend = 1'b1;
                                if (byteNum == 0) begin
                                    ackPend = (shift[7:1] == SlvAddr);
                                    txPend = shift[0];
                                end else if (byteNum == 1) begin
                                    regPtr = shift;
                                end else if (byteNum == 2) begin
                                    slvMem[regPtr] = shift;
                                end
                            end
                        end else begin
                            bitPos = 0;
                            if (!rxMode) begin
                                if (sda) active = 1'b0;
                            end else begin
                                if (!ackPend) active = 1'b0;
                                byteNum++;
                                if (txPend) begin
                                    rxMode = 1'b0; txByte = slvMem[regPtr]; txPend = 1'b0;
                                end
                            end
                        end
                    end
                end else if (prevScl && !scl) begin
                    slvSda = 1'b1;
                    if (active) begin
                        if (rxMode && bitPos == 8 && ackPend) slvSda = 1'b0;
                        else if (!rxMode && bitPos < 8) slvSda = txByte[7 - bitPos];
                    end
                end
                prevScl = scl;
                prevSda = sda;
            end
        end
    end

    // Reference model state.
    logic [7:0] modelMem [256];
    logic [7:0] modelRd;

    task automatic doXfer(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [7:0] wd, input bit extraReq);
        int s0, r0, p0, rise0, d0, cyc, slots, limit;
        logic expErr;
        logic [7:0] expRd;
        expErr = (dev != SlvAddr);
        slots = expErr ? 11 : (rd ? 39 : 29);
        expRd = (rd && !expErr) ? modelMem[ra] : modelRd;
        limit = 1 + 4 * ClkDiv * slots + 50;
        s0 = startCnt; r0 = rstartCnt; p0 = stopCnt; rise0 = riseCnt; d0 = doneCnt;
        @(negedge clk);
        rdNotWr = rd; devAddr = dev; regAddr = ra; wrData = wd; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        rdNotWr = 1'($urandom); devAddr = 7'($urandom); regAddr = 8'($urandom);
        wrData = 8'($urandom);
        checkVal("busyAfterAccept", {31'd0, busy}, 1);
        cyc = 1;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (extraReq && cyc == 100) begin
                req = 1'b1; rdNotWr = ~rd; devAddr = ~dev;
            end else if (extraReq && cyc == 101) begin
                req = 1'b0;
            end
        end
        checkVal("doneLatency", cyc, 1 + 4 * ClkDiv * slots);
        checkVal("ackErr", {31'd0, ackErr}, {31'd0, expErr});
        checkVal("rdData", {24'd0, rdData}, {24'd0, expRd});
        checkVal("busyAtDone", {31'd0, busy}, 1);
        @(negedge clk);
        checkVal("donePulse", {31'd0, done}, 0);
        checkVal("busyAfterDone", {31'd0, busy}, 0);
        repeat (4) @(negedge clk);
        checkVal("doneCount", doneCnt - d0, 1);
        checkVal("ackErrHeld", {31'd0, ackErr}, {31'd0, expErr});
        checkVal("startCount", startCnt - s0, 1);
        checkVal("rstartCount", rstartCnt - r0, (rd && !expErr) ? 1 : 0);
        checkVal("stopCount", stopCnt - p0, 1);
        checkVal("sclRises", riseCnt - rise0, slots - 1);
        if (!rd && !expErr) modelMem[ra] = wd;
        modelRd = expRd;
    endtask

    initial begin
        int d0;
        logic [6:0] dev;
        for (int i = 0; i < 256; i++) modelMem[i] = 8'h00;
        modelMem[5] = 8'h3C;
        modelRd = 8'h00;
        rst = 1'b1; req = 1'b0; rdNotWr = 1'b0; devAddr = '0; regAddr = '0; wrData = '0;
        #1;
        checkVal("rstScl", {31'd0, sclOut}, 1);
        checkVal("rstSda", {31'd0, sdaOut}, 1);
        checkVal("rstBusy", {31'd0, busy}, 0);
        checkVal("rstDone", {31'd0, done}, 0);
        checkVal("rstAckErr", {31'd0, ackErr}, 0);
        checkVal("rstRdData", {24'd0, rdData}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Directed transactions.
        doXfer(1'b0, SlvAddr, 8'd2, 8'hA5, 1'b0);
        checkVal("slaveReg2", {24'd0, slvMem[2]}, 32'hA5);
        doXfer(1'b1, SlvAddr, 8'd5, 8'h00, 1'b0);
        doXfer(1'b0, 7'h7F, 8'd4, 8'h99, 1'b0);
        checkVal("slaveReg4", {24'd0, slvMem[4]}, {24'd0, modelMem[4]});
        doXfer(1'b0, SlvAddr, 8'd6, 8'h4E, 1'b1);
        doXfer(1'b1, SlvAddr, 8'd6, 8'h00, 1'b0);

        // Reset in the middle of slot 12 of a write.
        d0 = doneCnt;
        @(negedge clk);
        rdNotWr = 1'b0; devAddr = SlvAddr; regAddr = 8'd3; wrData = 8'h5A; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (12 * 4 * ClkDiv + 20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkVal("midRstScl", {31'd0, sclOut}, 1);
        checkVal("midRstSda", {31'd0, sdaOut}, 1);
        checkVal("midRstBusy", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelRd = 8'h00;
        repeat (3) @(negedge clk);
        checkVal("midRstNoDone", doneCnt - d0, 0);
        checkVal("midRstReg3", {24'd0, slvMem[3]}, {24'd0, modelMem[3]});
        doXfer(1'b0, SlvAddr, 8'd3, 8'h5A, 1'b0);
        doXfer(1'b1, SlvAddr, 8'd3, 8'h00, 1'b0);

        // Random transactions.
        for (int n = 0; n < 12; n++) begin
            dev = SlvAddr;
            if ($urandom_range(0, 3) == 0) begin
                dev = 7'($urandom_range(0, 127));
                if (dev == SlvAddr) dev = dev ^ 7'h01;
            end
            doXfer(1'($urandom), dev, 8'($urandom_range(0, 7)), 8'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
